// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: forward-mux selects and sequencer states.
package hazard_unit_pkg;

  typedef logic [1:0] forward_bus_t;

  localparam forward_bus_t NORMAL_INPUT = 2'b00;
  localparam forward_bus_t W2E_ALU      = 2'b01;
  localparam forward_bus_t M2E_ALU      = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  // M beats W; register 0 is hardwired and never forwarded.
  function automatic forward_bus_t alu_forward(
    input logic       regwrite_m,
    input logic [4:0] writereg_m,
    input logic       regwrite_w,
    input logic [4:0] writereg_w,
    input logic [4:0] src
  );
    if (regwrite_m && writereg_m != 5'd0 && writereg_m == src)
      return M2E_ALU;
    else if (regwrite_w && writereg_w != 5'd0 && writereg_w == src)
      return W2E_ALU;
    else
      return NORMAL_INPUT;
  endfunction

endpackage

// File: rtl/hazard_unit_md_sequencer.sv
// Multiply/divide sequencer: freezes F/D/E for LAT cycles, then pulses done for one cycle.
module md_sequencer
  import hazard_unit_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_div,
  output logic md_stall,
  output logic md_busy,
  output logic md_done
);

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  md_state_t  state, state_nxt;
  logic [5:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // DONE ignores start: the finished instruction is still sitting in E.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE: begin
        if (md_start) begin
          cnt_nxt   = md_div ? DIV_CNT : MUL_CNT;
          state_nxt = MD_RUN;
        end
      end
      MD_RUN: begin
        if (cnt == 6'd1) state_nxt = MD_DONE;
        else             cnt_nxt   = cnt - 6'd1;
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Gating with rst drops the stall in the same cycle reset is asserted.
  assign md_stall = ~rst & (((state == MD_IDLE) & md_start) | (state == MD_RUN));
  assign md_busy  = (state == MD_RUN) | (state == MD_DONE);
  assign md_done  = (state == MD_DONE);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: ALU/branch forwarding, load-use and branch stalls, mult/div freeze.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   rsD,
  input  logic [4:0]   rtD,
  input  logic [4:0]   rsE,
  input  logic [4:0]   rtE,
  input  logic         branchD,
  input  logic         regwriteE,
  input  logic         regwriteM,
  input  logic         regwriteW,
  input  logic [4:0]   writeregE,
  input  logic [4:0]   writeregM,
  input  logic [4:0]   writeregW,
  input  logic         memtoregE,
  input  logic         memtoregM,
  input  logic         md_startE,
  input  logic         md_divE,
  output forward_bus_t forwardalu_A,
  output forward_bus_t forwardalu_B,
  output logic         forwardbr_A,
  output logic         forwardbr_B,
  output logic         stallF,
  output logic         stallD,
  output logic         stallE,
  output logic         flushE,
  output logic         flushM,
  output logic         md_busy,
  output logic         md_done
);

  logic md_stall;
  logic lwstall, brstall;
  logic we_e, we_m_load, we_m;

  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_sequencer (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_startE),
    .md_div   (md_divE),
    .md_stall (md_stall),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  assign forwardalu_A = alu_forward(regwriteM, writeregM, regwriteW, writeregW, rsE);
  assign forwardalu_B = alu_forward(regwriteM, writeregM, regwriteW, writeregW, rtE);

  assign we_m        = regwriteM & (writeregM != 5'd0);
  assign forwardbr_A = we_m & (writeregM == rsD);
  assign forwardbr_B = we_m & (writeregM == rtD);

  assign lwstall = memtoregE & (writeregE != 5'd0) &
                   ((writeregE == rsD) | (writeregE == rtD));

  // Branch compares in D, so an E result or an M load is not yet forwardable.
  assign we_e      = regwriteE & (writeregE != 5'd0);
  assign we_m_load = memtoregM & (writeregM != 5'd0);
  assign brstall   = branchD &
                     ((we_e & ((writeregE == rsD) | (writeregE == rtD))) |
                      (we_m_load & ((writeregM == rsD) | (writeregM == rtD))));

  assign stallF = lwstall | brstall | md_stall;
  assign stallD = stallF;
  assign stallE = md_stall;
  assign flushM = md_stall;
  assign flushE = (lwstall | brstall) & ~md_stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic       branchD;
  logic       regwriteE, regwriteM, regwriteW;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       memtoregE, memtoregM;
  logic       md_startE, md_divE;
  logic [1:0] forwardalu_A, forwardalu_B;
  logic       forwardbr_A, forwardbr_B;
  logic       stallF, stallD, stallE, flushE, flushM;
  logic       md_busy, md_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .branchD(branchD),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .md_startE(md_startE), .md_divE(md_divE),
    .forwardalu_A(forwardalu_A), .forwardalu_B(forwardalu_B),
    .forwardbr_A(forwardbr_A), .forwardbr_B(forwardbr_B),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM),
    .md_busy(md_busy), .md_done(md_done)
  );

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; branchD = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    memtoregE = 0; memtoregM = 0; md_startE = 0; md_divE = 0;
  endtask

  // Advance to 1ns after the next rising edge; inputs change and settle there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step(); step();
    #1;
    checks++;
    if ({md_busy, md_done, stallF, stallD, stallE, flushE, flushM} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b sF=%b sD=%b sE=%b fE=%b fM=%b want all 0",
               md_busy, md_done, stallF, stallD, stallE, flushE, flushM);
    end
    rsE = 5'd5; regwriteM = 1; writeregM = 5'd5;
    #1;
    checks++;
    if (forwardalu_A !== 2'b10) begin
      failures++;
      $display("FAIL reset_comb_fwd got %b want 10", forwardalu_A);
    end
    clear_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_forward();
    rsE = 5'd5; regwriteM = 1; writeregM = 5'd5; regwriteW = 1; writeregW = 5'd5;
    #1;
    checks++;
    if (forwardalu_A !== 2'b10) begin
      failures++; $display("FAIL fwd_m_priority got %b want 10", forwardalu_A);
    end
    regwriteM = 0;
    #1;
    checks++;
    if (forwardalu_A !== 2'b01) begin
      failures++; $display("FAIL fwd_w got %b want 01", forwardalu_A);
    end
    rsE = 0; regwriteM = 1; writeregM = 0; writeregW = 0;
    #1;
    checks++;
    if (forwardalu_A !== 2'b00) begin
      failures++; $display("FAIL fwd_reg0 got %b want 00", forwardalu_A);
    end
    rtE = 5'd7; writeregW = 5'd7; writeregM = 5'd9;
    #1;
    checks++;
    if (forwardalu_B !== 2'b01 || forwardalu_A !== 2'b00) begin
      failures++; $display("FAIL fwd_b got A=%b B=%b want A=00 B=01", forwardalu_A, forwardalu_B);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_load_use();
    memtoregE = 1; writeregE = 5'd8; rtD = 5'd8;
    #1;
    checks++;
    if ({stallF, stallD, flushE, stallE, flushM} !== 5'b11100) begin
      failures++;
      $display("FAIL lwstall got sF=%b sD=%b fE=%b sE=%b fM=%b want 1 1 1 0 0",
               stallF, stallD, flushE, stallE, flushM);
    end
    step();
    memtoregE = 0;
    #1;
    checks++;
    if ({stallF, stallD, flushE, stallE, flushM} !== 5'b0) begin
      failures++;
      $display("FAIL lw_release got sF=%b sD=%b fE=%b sE=%b fM=%b want 0",
               stallF, stallD, flushE, stallE, flushM);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_branch();
    branchD = 1; rsD = 5'd3; regwriteE = 1; writeregE = 5'd3;
    #1;
    checks++;
    if ({stallF, stallD, flushE} !== 3'b111) begin
      failures++; $display("FAIL br_e_dep got sF=%b sD=%b fE=%b want 111", stallF, stallD, flushE);
    end
    step();
    regwriteE = 0; writeregE = 0; memtoregM = 1; writeregM = 5'd3;
    #1;
    checks++;
    if ({stallF, stallD} !== 2'b11) begin
      failures++; $display("FAIL br_m_load got sF=%b sD=%b want 11", stallF, stallD);
    end
    step();
    memtoregM = 0; regwriteM = 1;
    #1;
    checks++;
    if ({stallF, stallD, flushE, forwardbr_A, forwardbr_B} !== 5'b00010) begin
      failures++;
      $display("FAIL br_fwd got sF=%b sD=%b fE=%b brA=%b brB=%b want 0 0 0 1 0",
               stallF, stallD, flushE, forwardbr_A, forwardbr_B);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_multiply();
    md_startE = 1; md_divE = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({stallF, stallD, stallE, flushM, md_done} !== 5'b11110) begin
        failures++;
        $display("FAIL mul_stall_t%0d got sF=%b sD=%b sE=%b fM=%b done=%b want 1 1 1 1 0",
                 i, stallF, stallD, stallE, flushM, md_done);
      end
      step();
    end
    #1;
    checks++;
    if ({md_done, md_busy, stallE, stallF, flushM} !== 5'b11000) begin
      failures++;
      $display("FAIL mul_done got done=%b busy=%b sE=%b sF=%b fM=%b want 1 1 0 0 0",
               md_done, md_busy, stallE, stallF, flushM);
    end
    step();
    md_startE = 0;
    #1;
    checks++;
    if ({md_busy, md_done, stallE} !== 3'b000) begin
      failures++;
      $display("FAIL mul_idle got busy=%b done=%b sE=%b want 000", md_busy, md_done, stallE);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_divide_reset();
    int n;
    md_startE = 1; md_divE = 1;
    for (int i = 0; i < 10; i++) step();
    #1;
    checks++;
    if ({md_busy, stallE} !== 2'b11) begin
      failures++; $display("FAIL div_running got busy=%b sE=%b want 11", md_busy, stallE);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({md_busy, md_done, stallF, stallD, stallE, flushM} !== 6'b0) begin
      failures++;
      $display("FAIL div_async_rst got busy=%b done=%b sF=%b sD=%b sE=%b fM=%b want 0",
               md_busy, md_done, stallF, stallD, stallE, flushM);
    end
    step();
    rst = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 40 && stallE === 1'b1; i++) begin
      n++;
      step();
    end
    checks++;
    if (n !== 32) begin
      failures++; $display("FAIL div_stall_len got %0d want 32", n);
    end
    checks++;
    if (md_done !== 1'b1) begin
      failures++; $display("FAIL div_done got %b want 1", md_done);
    end
    step();
    md_startE = 0; md_divE = 0;
    clear_inputs();
    step();
  endtask

  task automatic test_overlap();
    md_startE = 1; memtoregE = 1; writeregE = 5'd8; rtD = 5'd8;
    #1;
    checks++;
    if ({flushE, stallE, stallD, stallF} !== 4'b0111) begin
      failures++;
      $display("FAIL overlap got fE=%b sE=%b sD=%b sF=%b want 0 1 1 1",
               flushE, stallE, stallD, stallF);
    end
    for (int i = 0; i < 4; i++) step();
    #1;
    checks++;
    if ({md_done, flushE, stallE, stallD} !== 4'b1101) begin
      failures++;
      $display("FAIL overlap_release got done=%b fE=%b sE=%b sD=%b want 1 1 0 1",
               md_done, flushE, stallE, stallD);
    end
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_multiply();
    test_divide_reset();
    test_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It drives the select codes of the E-stage ALU operand forwarding muxes and the D-stage branch-comparator forwarding. It generates stall/flush for load-use and branch hazards, and it sequences the iterative multiply/divide unit by freezing F/D/E for a fixed latency. It sits beside the datapath and receives register indices and control bits from the D, E, M and W pipeline registers.

## Interface
- `MUL_LAT`, 4, E-stage cycles a MULT/MULTU occupies (≥2)
- `DIV_LAT`, 32, E-stage cycles a DIV/DIVU occupies (≥2, ≤63)
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rsD`, `rtD`  in  5 each  source register indices in D
- `rsE`, `rtE`  in  5 each  source register indices in E
- `branchD`  in  1  D holds a branch that compares in D
- `regwriteE`, `regwriteM`, `regwriteW`  in  1 each  stage writes the register file
- `writeregE`, `writeregM`, `writeregW`  in  5 each  destination index per stage
- `memtoregE`, `memtoregM`  in  1 each  stage holds a load
- `md_startE`  in  1  E holds a multiply/divide
- `md_divE`  in  1  qualifies `md_startE`: 1 = divide, 0 = multiply
- `forwardalu_A`, `forwardalu_B`  out  `ForwardBus` (2)  ALU operand selects
- `forwardbr_A`, `forwardbr_B`  out  1 each  branch operand from M ALU result
- `stallF`, `stallD`, `stallE`  out  1 each  hold the stage register
- `flushE`, `flushM`  out  1 each  insert a bubble into that stage register
- `md_busy`  out  1  multiply/divide sequencer not idle
- `md_done`  out  1  one-cycle pulse: HI/LO result valid this cycle

## Operation
- ALU forward, per operand (shown for A with `rsE`; B uses `rtE`):
  - `M2E_ALU` when `regwriteM`, `writeregM != 0` and `writeregM == rsE`.
  - Otherwise `W2E_ALU` when `regwriteW`, `writeregW != 0` and `writeregW == rsE`.
  - Otherwise `Normal_Input`.
  - M has priority over W. Register 0 is never forwarded.
- Branch forward: `forwardbr_A = regwriteM & writeregM != 0 & writeregM == rsD`. `forwardbr_B` is the same using `rtD`.
- Load-use stall (`lwstall`): `memtoregE & writeregE != 0` and (`writeregE == rsD` or `writeregE == rtD`).
- Branch stall (`brstall`): `branchD` and either of:
  - `regwriteE & writeregE != 0` matching `rsD` or `rtD`;
  - `memtoregM & writeregM != 0` matching `rsD` or `rtD`.
- Multiply/divide sequencer states:
  - IDLE:
    - `md_startE=1` loads `cnt` with LAT−1, where LAT = `md_divE ? DIV_LAT : MUL_LAT`.
    - The state then moves to RUN.
  - RUN:
    - When `cnt == 1`, the state moves to DONE.
    - Otherwise `cnt` decrements.
  - DONE:
    - `md_done=1` and `md_startE` is ignored, because it is the same instruction still in E.
    - The state always returns to IDLE.
- `md_stall = (IDLE & md_startE) | RUN`. `md_busy = RUN | DONE`.
- Stall and flush outputs:
  - `stallF = stallD = lwstall | brstall | md_stall`.
  - `stallE = md_stall`. `flushM = md_stall`.
  - `flushE = (lwstall | brstall) & ~md_stall`. E is never flushed while it holds a frozen mult/div.
- Counter is 6 bits, unsigned. No wrap occurs, since LAT ≤ 63.

## Timing
- Forward selects, `lwstall`, `brstall` and all stall/flush outputs are combinational from the current-cycle inputs and state. Stage registers act on the next edge.
- MD latency, with start seen in IDLE at cycle t:
  - Stall is high for cycles t..t+LAT−1.
  - `md_done` is high at t+LAT, with stall low.
  - The state is IDLE at t+LAT+1.
- Reset values:
  - State IDLE, `cnt`=0.
  - While `rst` is high, `md_busy`=`md_done`=0 and the sequencer cannot leave IDLE.
  - The combinational outputs still follow their inputs.
- `rst` asserted mid-RUN forces IDLE immediately and asynchronously. The stalls owned by the sequencer drop in the same cycle.
- Simultaneous `lwstall` and `md_stall`: F/D stall and E stays frozen (`flushE`=0). The load-use check is re-evaluated after the release.

## Structure
- `ForwardBus` and the forward encodings belong in the shared `stddef.v` header, one `define each:
  - `Normal_Input` = 2'b00
  - `W2E_ALU` = 2'b01
  - `M2E_ALU` = 2'b10
- The sequencer state encodings (`MD_IDLE`, `MD_RUN`, `MD_DONE`) are defined there as well.
- One sub-module is natural: `md_sequencer`, holding the FSM, the counter and the `md_stall`/`md_busy`/`md_done` outputs. Forwarding and the hazard equations stay in `hazard_unit`.

## Test plan
- Forward priority: `rsE=5`, `regwriteM=1 writeregM=5`, `regwriteW=1 writeregW=5` → `forwardalu_A=M2E_ALU`. Drop `regwriteM` → `W2E_ALU`. Set `rsE=0` with writes to 0 → `Normal_Input`.
- Load-use: `memtoregE=1 writeregE=8`, `rtD=8` → stallF=stallD=flushE=1, stallE=0. Next cycle with `memtoregE=0` → all stall/flush outputs 0.
- Branch: `branchD=1 rsD=3`, `regwriteE=1 writeregE=3` → stall plus flushE. Then `memtoregM=1 writeregM=3` → stall. Then `regwriteM=1 writeregM=3`, non-load → no stall, `forwardbr_A=1`.
- Multiply: `md_startE=1 md_divE=0` held in IDLE at t → stallF/D/E, flushM high for t..t+3; `md_done=1` at t+4; IDLE at t+5. A start held during DONE causes no restart.
- Divide with reset: start divide at t, assert `rst` at t+10 → IDLE, all stalls 0, `md_busy`=0 immediately. After release, a new divide gives 32 stall cycles.
- Overlap: `md_stall` active and `lwstall` true → `flushE=0`, `stallE=1`, `stallD=1`.
